// File: rtl/encoder_velocity_sampler.sv
// Encoder velocity sampler: signed position delta per fixed window with
// valid/ready hand-off, sticky overrun flag and stall detection.
module encoder_velocity_sampler #(
  parameter int unsigned SAMPLE_CYCLES = 1000000,
  parameter int unsigned STALL_SAMPLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] count,
  input  logic        zero_cntrs,
  output logic [23:0] vel,
  output logic        vel_valid,
  input  logic        vel_ready,
  output logic        overrun,
  input  logic        clear_overrun,
  output logic        stall,
  output logic        window_tick
);

  localparam int unsigned TW = (SAMPLE_CYCLES > 2) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_CYCLES - 1);
  localparam logic [7:0]    STALL_MAX  = 8'(STALL_SAMPLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic [23:0]   prev;
  logic [23:0]   delta;
  logic [7:0]    stall_cnt;
  logic          start, leave;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start       = (state == IDLE) && enable;
    leave       = (state == RUN) && !enable;
    window_tick = (state == RUN) && (timer == TIMER_LAST);
  end

  assign delta = count - prev;
  assign stall = (stall_cnt == STALL_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if ((state == RUN) && enable) begin
      timer <= window_tick ? '0 : timer + TW'(1);
    end else begin
      timer <= '0;
    end
  end

  // A counter clear zeroes prev even on a tick; vel still uses the old prev.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       prev <= '0;
    else if (zero_cntrs)           prev <= '0;
    else if (start || window_tick) prev <= count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vel       <= '0;
      vel_valid <= 1'b0;
    end else if (window_tick) begin
      vel       <= delta;
      vel_valid <= 1'b1;
    end else if (vel_valid && vel_ready) begin
      vel_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      overrun <= 1'b0;
    else if (window_tick && vel_valid && !vel_ready) overrun <= 1'b1;
    else if (clear_overrun)                       overrun <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (leave) begin
      stall_cnt <= '0;
    end else if (window_tick) begin
      if (delta != '0)              stall_cnt <= '0;
      else if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_encoder_velocity_sampler.sv
// Directed bench for encoder_velocity_sampler (SAMPLE_CYCLES=10, STALL_SAMPLES=3).
module tb_encoder_velocity_sampler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [23:0] count = '0;
  logic        zero_cntrs = 1'b0;
  logic [23:0] vel;
  logic        vel_valid;
  logic        vel_ready = 1'b1;
  logic        overrun;
  logic        clear_overrun = 1'b0;
  logic        stall;
  logic        window_tick;

  logic        ramp = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  encoder_velocity_sampler #(.SAMPLE_CYCLES(10), .STALL_SAMPLES(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .count(count),
    .zero_cntrs(zero_cntrs), .vel(vel), .vel_valid(vel_valid),
    .vel_ready(vel_ready), .overrun(overrun), .clear_overrun(clear_overrun),
    .stall(stall), .window_tick(window_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (ramp) count = count + 24'd1;
  endtask

  task automatic wait_tick(input int unsigned max, output int unsigned n);
    n = 0;
    while (!window_tick && n < max) begin
      cyc();
      n++;
    end
    if (!window_tick) check("tick_timeout", 32'd0, 32'd1);
  endtask

  int unsigned n;
  logic        saw;

  initial begin
    // reset state
    repeat (3) cyc();
    check("rst_vel", 32'(vel), 32'd0);
    check("rst_valid", 32'(vel_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_tick", 32'(window_tick), 32'd0);
    rst = 1'b0;
    cyc();

    // ramp +1/cycle gives vel=10 each 10-cycle window
    enable = 1'b1; ramp = 1'b1; vel_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_tick(25, n);
      if (k > 0) check("ramp_period", 32'(n), 32'd8);
      cyc();
      check("ramp_vel", 32'(vel), 32'd10);
      check("ramp_valid_on", 32'(vel_valid), 32'd1);
      cyc();
      check("ramp_valid_off", 32'(vel_valid), 32'd0);
    end

    // wraparound deltas
    enable = 1'b0; ramp = 1'b0;
    cyc();
    count = 24'hFFFFFE; enable = 1'b1;
    cyc();
    count = 24'h000002;
    wait_tick(25, n);
    cyc();
    check("wrap_pos", 32'(vel), 32'h000004);
    count = 24'hFFFFFE;
    wait_tick(25, n);
    cyc();
    check("wrap_neg", 32'(vel), 32'hFFFFFC);
    cyc();

    // overrun: deltas 5 then 7 while consumer stalls
    vel_ready = 1'b0; count = 24'h000003;
    wait_tick(25, n);
    cyc();
    check("ovr_vel1", 32'(vel), 32'd5);
    check("ovr_over1", 32'(overrun), 32'd0);
    count = 24'h00000A;
    wait_tick(25, n);
    cyc();
    check("ovr_vel2", 32'(vel), 32'd7);
    check("ovr_valid2", 32'(vel_valid), 32'd1);
    check("ovr_over2", 32'(overrun), 32'd1);
    clear_overrun = 1'b1;
    cyc();
    clear_overrun = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);
    check("ovr_valid_kept", 32'(vel_valid), 32'd1);
    check("ovr_vel_kept", 32'(vel), 32'd7);
    vel_ready = 1'b1;
    cyc();
    check("ovr_drained", 32'(vel_valid), 32'd0);

    // stall after 3 zero windows, saturating, cleared by motion and by disable
    for (int w = 1; w <= 4; w++) begin
      wait_tick(25, n);
      cyc();
      check("stall_build", 32'(stall), (w >= 3) ? 32'd1 : 32'd0);
    end
    count = 24'h00000B;
    wait_tick(25, n);
    cyc();
    check("stall_motion", 32'(stall), 32'd0);
    check("stall_motion_vel", 32'(vel), 32'd1);
    for (int w = 1; w <= 3; w++) begin
      wait_tick(25, n);
      cyc();
    end
    check("stall_again", 32'(stall), 32'd1);
    enable = 1'b0;
    cyc();
    check("stall_disable", 32'(stall), 32'd0);

    // zero_cntrs mid-window: no spurious -100
    count = 24'd100; enable = 1'b1;
    cyc();
    cyc(); cyc();
    zero_cntrs = 1'b1;
    cyc();
    zero_cntrs = 1'b0; count = 24'd0;
    cyc();
    count = 24'd3;
    cyc();
    count = 24'd6;
    wait_tick(25, n);
    cyc();
    check("zero_vel", 32'(vel), 32'd6);
    check("zero_valid", 32'(vel_valid), 32'd1);

    // reset mid-window with pending sample
    vel_ready = 1'b0;
    repeat (5) cyc();
    check("pre_rst_valid", 32'(vel_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_vel", 32'(vel), 32'd0);
    check("arst_valid", 32'(vel_valid), 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    check("arst_stall", 32'(stall), 32'd0);
    check("arst_tick", 32'(window_tick), 32'd0);
    #2;
    ramp = 1'b1; vel_ready = 1'b1; rst = 1'b0;
    cyc();
    saw = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      saw = saw | vel_valid;
    end
    check("post_rst_no_early", 32'(saw), 32'd0);
    cyc();
    check("post_rst_valid", 32'(vel_valid), 32'd1);
    check("post_rst_vel", 32'(vel), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/encoder_velocity_sampler.md
ENCODER_VELOCITY_SAMPLER -- requirements
Module: encoder_velocity_sampler

Interface
REQ-001 SHALL have parameter SAMPLE_CYCLES, default 1000000, clk cycles per velocity window (10 ms at 100 MHz); legal range >=2.
REQ-002 SHALL have parameter STALL_SAMPLES, default 8, consecutive zero-delta windows before stall asserts; legal range 1..255.
REQ-003 SHALL have port clk  input  1  system clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port enable  input  1  1 = sampling runs, 0 = idle.
REQ-006 SHALL have port count  input  24  encoder up/down position count, two's-complement wrap.
REQ-007 SHALL have port zero_cntrs  input  1  encoder counter being cleared this cycle.
REQ-008 SHALL have port vel  output  24  signed counts per window.
REQ-009 SHALL have port vel_valid  output  1  vel holds an unaccepted sample.
REQ-010 SHALL have port vel_ready  input  1  consumer accepts vel when vel_valid=1.
REQ-011 SHALL have port overrun  output  1  sticky: unaccepted sample was overwritten.
REQ-012 SHALL have port clear_overrun  input  1  synchronous clear of overrun.
REQ-013 SHALL have port stall  output  1  motor stalled (STALL_SAMPLES zero-delta windows).
REQ-014 SHALL have port window_tick  output  1  one-cycle pulse at each window end.

Function
REQ-015 SHALL implement states IDLE and RUN; IDLE->RUN when enable=1, RUN->IDLE when enable=0.
REQ-016 On IDLE->RUN transition cycle, SHALL load prev <= count and timer <= 0; no sample is produced.
REQ-017 In RUN, timer SHALL count 0..SAMPLE_CYCLES-1 and wrap to 0; window_tick=1 combinationally in the cycle timer==SAMPLE_CYCLES-1.
REQ-018 On window_tick, SHALL compute delta = (count - prev) mod 2^24 as signed 24-bit, register vel <= delta and prev <= count.
REQ-019 vel_valid SHALL assert on the clock edge following the window_tick cycle (latency 1 cycle from tick to vel/vel_valid).
REQ-020 Transfer SHALL occur in any cycle with vel_valid=1 and vel_ready=1; vel_valid SHALL clear on that edge unless a new sample loads on the same edge.
REQ-021 Tick with vel_valid=1 and vel_ready=0: vel SHALL be overwritten with newest delta, vel_valid stays 1, overrun SHALL set.
REQ-022 Tick with vel_valid=1 and vel_ready=1: old sample transfers, new sample loads, vel_valid stays 1, overrun unchanged.
REQ-023 overrun SHALL hold until clear_overrun=1; if set and clear coincide, set SHALL win.
REQ-024 zero_cntrs=1 SHALL load prev <= 0 (takes priority over REQ-018 prev update; vel still uses pre-clear prev for that tick).
REQ-025 Stall counter SHALL increment (saturating at STALL_SAMPLES) on each tick with delta==0, reset to 0 on tick with delta!=0; stall=1 iff counter==STALL_SAMPLES.
REQ-026 Entering IDLE SHALL clear timer and stall counter; a pending vel/vel_valid SHALL remain until transferred.
REQ-027 vel_ready while vel_valid=0 SHALL have no effect.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, timer 0, prev 0, vel 0, vel_valid 0, overrun 0, stall counter 0, stall 0, window_tick 0.
REQ-029 rst SHALL be honoured in any state, including mid-window and with a pending sample; no sample SHALL emerge from a window interrupted by reset.

Verification (SAMPLE_CYCLES=10, STALL_SAMPLES=3)
REQ-030 enable=1, count ramps +1 per cycle, vel_ready=1 -> vel=10 one cycle after each window_tick, vel_valid 1-cycle pulses every 10 cycles.
REQ-031 prev=24'hFFFFFE, count=24'h000002 at tick -> vel=24'h000004 (+4); prev=24'h000002, count=24'hFFFFFE -> vel=24'hFFFFFC (-4).
REQ-032 vel_ready=0 across two ticks with deltas 5 then 7 -> vel=7, vel_valid=1, overrun=1; clear_overrun pulse -> overrun=0, vel_valid unchanged.
REQ-033 count constant for 3 windows -> stall=1 after third tick; one window with delta 1 -> stall=0; enable=0 -> stall=0.
REQ-034 zero_cntrs pulse with count=100 then count ramps to 6 by next tick -> next vel=6, no spurious -100.
REQ-035 rst asserted at timer=5 with vel_valid=1 -> all outputs 0 same cycle; after release and enable=1, first vel_valid only after a full 10-cycle window.
